// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM encoder/decoder pair: default widths and decoder FSM states.
package rgb_pkg;
  localparam int PWM_W_DEF  = 8;
  localparam int PERIOD_DEF = 256;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/pwm_duty_meter.sv
// One PWM channel: input synchronizer plus a high-cycle counter that yields a saturated duty
// value on the cycle the shared window counter wraps.
module pwm_duty_meter
  import rgb_pkg::*;
#(
  parameter int PWM_W       = PWM_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm,
  input  logic             win_wrap,
  output logic [PWM_W-1:0] result
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   bit_s;
  logic [PWM_W:0]         cnt;
  logic [PWM_W:0]         sum;

  function automatic logic [PWM_W-1:0] saturate(input logic [PWM_W:0] v);
    return v[PWM_W] ? {PWM_W{1'b1}} : v[PWM_W-1:0];
  endfunction

  assign bit_s  = sync[SYNC_STAGES-1];
  assign sum    = cnt + {{PWM_W{1'b0}}, bit_s};
  assign result = saturate(sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm};
    end
  end

  // Once the overflow bit is set the count sticks, so long windows still saturate cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (win_wrap) begin
      cnt <= '0;
    end else if (!cnt[PWM_W]) begin
      cnt <= sum;
    end
  end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Recovers the 8-bit duty of three PWM lines by counting high cycles over a free-running
// PERIOD-cycle window; flags stable when two consecutive decoded triplets match.
module rgb_pwm_decoder
  import rgb_pkg::*;
#(
  parameter int PWM_W       = PWM_W_DEF,
  parameter int PERIOD      = PERIOD_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rin,
  input  logic             gin,
  input  logic             bin,
  output logic [PWM_W-1:0] rout,
  output logic [PWM_W-1:0] gout,
  output logic [PWM_W-1:0] bout,
  output logic             valid,
  output logic             stable
);

  localparam int WIN_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [WIN_W-1:0] win;
  logic             win_wrap;
  logic [PWM_W-1:0] res_r, res_g, res_b;
  state_t           state, state_nx;
  logic             load;

  assign win_wrap = (win == WIN_W'(PERIOD - 1));

  // No alignment to PWM edges is needed: any full window of a periodic signal has the same count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
    end else begin
      win <= win_wrap ? '0 : win + 1'b1;
    end
  end

  pwm_duty_meter #(.PWM_W(PWM_W), .SYNC_STAGES(SYNC_STAGES)) u_meter_r (
    .clk(clk), .rst(rst), .pwm(rin), .win_wrap(win_wrap), .result(res_r)
  );
  pwm_duty_meter #(.PWM_W(PWM_W), .SYNC_STAGES(SYNC_STAGES)) u_meter_g (
    .clk(clk), .rst(rst), .pwm(gin), .win_wrap(win_wrap), .result(res_g)
  );
  pwm_duty_meter #(.PWM_W(PWM_W), .SYNC_STAGES(SYNC_STAGES)) u_meter_b (
    .clk(clk), .rst(rst), .pwm(bin), .win_wrap(win_wrap), .result(res_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FLUSH;
    end else begin
      state <= state_nx;
    end
  end

  // The first window after reset holds synchronizer fill and is thrown away.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    if (state == ST_FLUSH) begin
      if (win_wrap) begin
        state_nx = ST_RUN;
      end
    end else begin
      load = win_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rout   <= '0;
      gout   <= '0;
      bout   <= '0;
      valid  <= 1'b0;
      stable <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        rout   <= res_r;
        gout   <= res_g;
        bout   <= res_b;
        stable <= ({res_r, res_g, res_b} == {rout, gout, bout});
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Randomized bench for rgb_pwm_decoder: a window-sum reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_rgb_pwm_decoder;

  localparam int W    = 8;
  localparam int P    = 256;
  localparam int S    = 2;
  localparam int HMAX = 65536;
  localparam int SATV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rin = 1'b0, gin = 1'b0, bin = 1'b0;
  logic [W-1:0] rout, gout, bout;
  logic         valid, stable;

  always #5 clk = ~clk;

  rgb_pwm_decoder #(.PWM_W(W), .PERIOD(P), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .rin(rin), .gin(gin), .bin(bin),
    .rout(rout), .gout(gout), .bout(bout), .valid(valid), .stable(stable)
  );

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus source: mode 0 = PWM with duty, 1 = tied 0, 2 = tied 1, 3 = toggle each clk.
  int   mode[3];
  int   duty[3];
  int   ph[3];
  logic drv[3];

  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        ph[c] = (ph[c] + 1) % P;
        case (mode[c])
          0:       drv[c] = (ph[c] < duty[c]);
          1:       drv[c] = 1'b0;
          2:       drv[c] = 1'b1;
          default: drv[c] = ~drv[c];
        endcase
      end
      rin = drv[0];
      gin = drv[1];
      bin = drv[2];
    end
  end

  // Reference model: history of sampled inputs since reset release; each window result is the
  // saturated count of highs seen S edges late, published one cycle after every wrap past the first.
  logic [2:0] hist[HMAX];
  int e = 0;
  int prev[3];
  int expv[3];
  int held_stable = 0;
  int sum, idx, st;

  always @(posedge clk) begin
    if (rst) begin
      e++;
      if (e < HMAX) hist[e] = {bin, gin, rin};
      #1;
      if ((e % P == 0) && (e >= 2 * P)) begin
        for (int c = 0; c < 3; c++) begin
          sum = 0;
          for (int k = e - P + 1; k <= e; k++) begin
            idx = k - S;
            if (idx >= 1 && idx < HMAX) sum += int'(hist[idx][c]);
          end
          expv[c] = (sum > SATV) ? SATV : sum;
        end
        st = (expv[0] == prev[0] && expv[1] == prev[1] && expv[2] == prev[2]) ? 1 : 0;
        chk("valid_at_wrap", valid, 1);
        chk("rout_model", rout, expv[0]);
        chk("gout_model", gout, expv[1]);
        chk("bout_model", bout, expv[2]);
        chk("stable_model", stable, st);
        prev = expv;
        held_stable = st;
      end else begin
        chk("valid_idle", valid, 0);
        chk("rout_hold", rout, prev[0]);
        chk("gout_hold", gout, prev[1]);
        chk("bout_hold", bout, prev[2]);
        chk("stable_hold", stable, held_stable);
      end
    end
  end

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if (valid) break;
      if (n >= maxc) begin
        ncmp++;
        nfail++;
        $display("FAIL valid_timeout: no valid within %0d clk", maxc);
        break;
      end
    end
  endtask

  task automatic set_pwm(input int d0, input int d1, input int d2);
    mode[0] = 0; mode[1] = 0; mode[2] = 0;
    duty[0] = d0; duty[1] = d1; duty[2] = d2;
  endtask

  task automatic model_reset();
    e = 0;
    held_stable = 0;
    for (int c = 0; c < 3; c++) prev[c] = 0;
  endtask

  int n;

  initial begin
    for (int c = 0; c < 3; c++) begin
      ph[c]  = int'($urandom_range(0, P - 1));
      drv[c] = 1'b0;
    end
    model_reset();
    set_pwm(32, 0, 0);

    // Reset state while the inputs are already toggling.
    repeat (3) @(negedge clk);
    chk("reset_rout", rout, 0);
    chk("reset_valid", valid, 0);
    chk("reset_stable", stable, 0);
    @(negedge clk);
    rst = 1'b1;

    // Duties 32/0/0: first result after two windows, then stable.
    wait_valid(3 * P, n);
    chk("first_latency", n, 2 * P);
    chk("t1_rout", rout, 32);
    chk("t1_gout", gout, 0);
    chk("t1_bout", bout, 0);
    chk("t1_stable0", stable, 0);
    wait_valid(2 * P, n);
    chk("t1_spacing", n, P);
    chk("t1_rout2", rout, 32);
    chk("t1_stable1", stable, 1);

    // Duties 255/128/1.
    set_pwm(255, 128, 1);
    wait_valid(2 * P, n);
    wait_valid(2 * P, n);
    chk("t2_spacing", n, P);
    chk("t2_rout", rout, 255);
    chk("t2_gout", gout, 128);
    chk("t2_bout", bout, 1);

    // Tied high saturates, tied low, toggling gives half.
    mode[0] = 2; mode[1] = 1; mode[2] = 3;
    wait_valid(2 * P, n);
    wait_valid(2 * P, n);
    chk("t3_rout_sat", rout, 255);
    chk("t3_gout", gout, 0);
    chk("t3_bout", bout, 128);
    wait_valid(2 * P, n);
    chk("t3_stable", stable, 1);

    // Red duty change 32 -> 200 in the middle of a window.
    set_pwm(32, 0, 0);
    wait_valid(2 * P, n);
    wait_valid(2 * P, n);
    wait_valid(2 * P, n);
    repeat (128) @(negedge clk);
    duty[0] = 200;
    wait_valid(2 * P, n);
    chk("t4_mid_range", (rout > 32 && rout < 200) ? 1 : 0, 1);
    chk("t4_mid_stable", stable, 0);
    wait_valid(2 * P, n);
    chk("t4_new_rout", rout, 200);
    chk("t4_new_stable0", stable, 0);
    wait_valid(2 * P, n);
    chk("t4_new_rout2", rout, 200);
    chk("t4_new_stable1", stable, 1);

    // Asynchronous reset in the middle of a RUN window.
    repeat (100) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_async_rout", rout, 0);
    chk("t5_async_valid", valid, 0);
    chk("t5_async_stable", stable, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_valid(3 * P, n);
    chk("t5_relatency", n, 2 * P);
    chk("t5_rout", rout, 200);

    // Randomized modes, duties and phases.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        mode[c] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        duty[c] = int'($urandom_range(0, 255));
        ph[c]   = int'($urandom_range(0, P - 1));
      end
      for (int k = 0; k < 3; k++) wait_valid(2 * P, n);
      chk("rand_spacing", n, P);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
